// File: rtl/ahb_mon_pkg.sv
// ahb_mon_pkg: AHB-Lite encodings, in-flight record and saturating add shared by the monitor
package ahb_mon_pkg;
   localparam logic [1:0] HTRANS_IDLE = 2'b00, HTRANS_BUSY = 2'b01, HTRANS_NONSEQ = 2'b10, HTRANS_SEQ = 2'b11;
   localparam logic [1:0] HRESP_OKAY = 2'b00, HRESP_ERROR = 2'b01;
   localparam int A_RD = 0, A_WR = 1, A_RDB = 2, A_WRB = 3, A_LAT = 4, A_ERR = 5, A_HIST = 6;
   typedef struct packed {
      logic       valid;
      logic       write;
      logic [2:0] size;
   } flight_t;
   function automatic logic [63:0] sat_add(logic [63:0] a, logic [63:0] b, logic [63:0] max);
      return (a + b > max) ? max : a + b;
   endfunction
   function automatic logic in_range(logic [63:0] a, logic [63:0] lo, logic [63:0] hi);
      return a >= lo && a <= hi;
   endfunction
endpackage

// File: rtl/ahb_perf_monitor_if.sv
// ahb_perf_monitor_if: AHB-Lite slave-port signals with master, slave and snoop views
interface ahb_perf_monitor_if #(parameter int ADDR_WIDTH = 32, parameter int DATA_WIDTH = 32);
   logic                  HSEL, HREADY, HWRITE;
   logic [ADDR_WIDTH-1:0] HADDR;
   logic [2:0]            HSIZE;
   logic [1:0]            HTRANS, HRESP;
   logic [DATA_WIDTH-1:0] HWDATA, HRDATA;
   modport master (output HSEL, HADDR, HWRITE, HSIZE, HTRANS, HWDATA, input HREADY, HRESP, HRDATA);
   modport slave (input HSEL, HADDR, HWRITE, HSIZE, HTRANS, HWDATA, output HREADY, HRESP, HRDATA);
   modport monitor (input HSEL, HREADY, HWRITE, HADDR, HSIZE, HTRANS, HRESP, HWDATA, HRDATA);
endinterface

// File: rtl/ahb_mon_sat_cnt.sv
// ahb_mon_sat_cnt: saturating accumulator exposing its post-increment (pre-clear) value
module ahb_mon_sat_cnt
   import ahb_mon_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int INC_W = 8
) (
   input  logic             HCLK,
   input  logic             HRESET,
   input  logic             inc_en,
   input  logic [INC_W-1:0] inc_val,
   input  logic             clr,
   output logic [WIDTH-1:0] nxt
);
   logic [WIDTH-1:0] cnt_q, cnt_d;
   always_comb begin
      nxt = inc_en ? WIDTH'(sat_add(64'(cnt_q), 64'(inc_val), 64'({WIDTH{1'b1}}))) : cnt_q;
      cnt_d = clr ? '0 : nxt;
   end
   always_ff @(posedge HCLK) cnt_q <= HRESET ? '0 : cnt_d;
endmodule

// File: rtl/ahb_perf_monitor.sv
// ahb_perf_monitor: windowed AHB-Lite count/byte/latency/error snooper emitting one snapshot per window
module ahb_perf_monitor
   import ahb_mon_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_W = 32,
   parameter int LAT_W = 8,
   parameter int WINDOW = 1024,
   parameter int NBINS = 8,
   parameter logic [ADDR_WIDTH-1:0] ADDR_LO = '0,
   parameter logic [ADDR_WIDTH-1:0] ADDR_HI = '1
) (
   input  logic                   HCLK,
   input  logic                   HRESET,
   input  logic                   mon_en,
   input  logic                   mon_clr,
   ahb_perf_monitor_if.monitor    bus,
   output logic                   snap_valid,
   output logic [CNT_W-1:0]       snap_rd_cnt,
   output logic [CNT_W-1:0]       snap_wr_cnt,
   output logic [CNT_W-1:0]       snap_rd_bytes,
   output logic [CNT_W-1:0]       snap_wr_bytes,
   output logic [CNT_W-1:0]       snap_lat_sum,
   output logic [LAT_W-1:0]       snap_lat_max,
   output logic [CNT_W-1:0]       snap_err_cnt,
   output logic [NBINS*CNT_W-1:0] snap_hist
);
   localparam int NACC = A_HIST + NBINS;
   localparam int INC_W = LAT_W > 8 ? LAT_W : 8;
   localparam int TW = $clog2(WINDOW);
   flight_t flight_q, flight_d;
   logic [LAT_W-1:0] lat_q, lat_d, lat_max_q, lat_max_d, lat_max_nxt, snap_lat_max_q, snap_lat_max_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [NACC-1:0] inc_en;
   logic [NACC-1:0][INC_W-1:0] inc_val;
   logic [NACC-1:0][CNT_W-1:0] acc_nxt, snap_q, snap_d;
   logic [INC_W-1:0] byte_v;
   logic snap_valid_q, snap_valid_d, accept, done, ev, roll, clr;
   logic [DATA_WIDTH-1:0] unused_data;
   assign unused_data = bus.HWDATA ^ bus.HRDATA;
   always_comb begin
      done = flight_q.valid & bus.HREADY;
      accept = bus.HSEL & bus.HREADY & (bus.HTRANS == HTRANS_NONSEQ || bus.HTRANS == HTRANS_SEQ)
               & in_range(64'(bus.HADDR), 64'(ADDR_LO), 64'(ADDR_HI));
      ev = done & mon_en & ~mon_clr;
      roll = mon_en & ~mon_clr & (timer_q == TW'(WINDOW - 1));
      clr = mon_clr | roll;
      flight_d = bus.HREADY ? flight_t'{valid: accept, write: bus.HWRITE, size: bus.HSIZE} : flight_q;
      lat_d = bus.HREADY ? LAT_W'(1) : (&lat_q ? lat_q : lat_q + LAT_W'(1));
      timer_d = clr ? '0 : timer_q + TW'(mon_en);
      byte_v = INC_W'(1) << flight_q.size;
      inc_en = '0;
      inc_en[A_RD] = ev & ~flight_q.write;
      inc_en[A_WR] = ev & flight_q.write;
      inc_en[A_RDB] = ev & ~flight_q.write;
      inc_en[A_WRB] = ev & flight_q.write;
      inc_en[A_LAT] = ev;
      inc_en[A_ERR] = ev & |(bus.HRESP & HRESP_ERROR);
      for (int i = 0; i < NBINS; i++)
         inc_en[A_HIST+i] = ev & (i == NBINS - 1 ? lat_q >= LAT_W'(NBINS) : lat_q == LAT_W'(i + 1));
      inc_val = {NACC{INC_W'(1)}};
      inc_val[A_RDB] = byte_v;
      inc_val[A_WRB] = byte_v;
      inc_val[A_LAT] = INC_W'(lat_q);
      lat_max_nxt = (ev && lat_q > lat_max_q) ? lat_q : lat_max_q;
      lat_max_d = clr ? '0 : lat_max_nxt;
      snap_d = roll ? acc_nxt : snap_q;
      snap_lat_max_d = roll ? lat_max_nxt : snap_lat_max_q;
      snap_valid_d = roll;
   end
   for (genvar k = 0; k < NACC; k++) begin : g_acc
      ahb_mon_sat_cnt #(.WIDTH(CNT_W), .INC_W(INC_W)) u_cnt (
         .HCLK(HCLK), .HRESET(HRESET), .inc_en(inc_en[k]), .inc_val(inc_val[k]), .clr(clr), .nxt(acc_nxt[k])
      );
   end
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         flight_q <= '0;
         lat_q <= '0;
         lat_max_q <= '0;
         timer_q <= '0;
         snap_q <= '0;
         snap_lat_max_q <= '0;
         snap_valid_q <= 1'b0;
      end else begin
         flight_q <= flight_d;
         lat_q <= lat_d;
         lat_max_q <= lat_max_d;
         timer_q <= timer_d;
         snap_q <= snap_d;
         snap_lat_max_q <= snap_lat_max_d;
         snap_valid_q <= snap_valid_d;
      end
   end
   assign snap_valid = snap_valid_q;
   assign snap_rd_cnt = snap_q[A_RD];
   assign snap_wr_cnt = snap_q[A_WR];
   assign snap_rd_bytes = snap_q[A_RDB];
   assign snap_wr_bytes = snap_q[A_WRB];
   assign snap_lat_sum = snap_q[A_LAT];
   assign snap_err_cnt = snap_q[A_ERR];
   assign snap_lat_max = snap_lat_max_q;
   assign snap_hist = snap_q[NACC-1:A_HIST];
endmodule

// File: tb/tb_ahb_perf_monitor.sv
// tb_ahb_perf_monitor: directed scoreboard bench for the windowed AHB-Lite performance monitor
module tb_ahb_perf_monitor;
   import ahb_mon_pkg::*;
   typedef logic [14:0][31:0] rec_t;
   logic HCLK = 1'b0, HRESET = 1'b1, mon_clr = 1'b0, mon_en_a = 1'b0, mon_en_b = 1'b0;
   int cycle = 0, errors = 0, checks = 0, t0 = 0;
   rec_t m = '0;
   rec_t q[$];
   logic a_v, s_v;
   logic [31:0] a_rd, a_wr, a_rdb, a_wrb, a_lat, a_err;
   logic [3:0] s_rd, s_wr, s_rdb, s_wrb, s_lat, s_err;
   logic [7:0] a_max, s_max;
   logic [255:0] a_hist;
   logic [31:0] s_hist;
   logic [5:0][31:0] a_f;
   logic [5:0][3:0] s_f;
   assign a_f = {a_err, a_lat, a_wrb, a_rdb, a_wr, a_rd};
   assign s_f = {s_err, s_lat, s_wrb, s_rdb, s_wr, s_rd};
   ahb_perf_monitor_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
   always #5 HCLK = ~HCLK;
   always @(posedge HCLK) cycle <= cycle + 1;
   ahb_perf_monitor #(.CNT_W(32), .WINDOW(16), .ADDR_LO(32'h1000), .ADDR_HI(32'h1FFF)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .mon_en(mon_en_a), .mon_clr(mon_clr), .bus(bus),
      .snap_valid(a_v), .snap_rd_cnt(a_rd), .snap_wr_cnt(a_wr), .snap_rd_bytes(a_rdb), .snap_wr_bytes(a_wrb),
      .snap_lat_sum(a_lat), .snap_lat_max(a_max), .snap_err_cnt(a_err), .snap_hist(a_hist)
   );
   ahb_perf_monitor #(.CNT_W(4), .WINDOW(32), .ADDR_LO(32'h1000), .ADDR_HI(32'h1FFF)) dut_s (
      .HCLK(HCLK), .HRESET(HRESET), .mon_en(mon_en_b), .mon_clr(mon_clr), .bus(bus),
      .snap_valid(s_v), .snap_rd_cnt(s_rd), .snap_wr_cnt(s_wr), .snap_rd_bytes(s_rdb), .snap_wr_bytes(s_wrb),
      .snap_lat_sum(s_lat), .snap_lat_max(s_max), .snap_err_cnt(s_err), .snap_hist(s_hist)
   );
   function automatic logic [31:0] obs(bit s, int f);
      if (f == 14) return s ? 32'(s_max) : 32'(a_max);
      if (f >= 6) return s ? 32'(s_hist[(f-6)*4 +: 4]) : a_hist[(f-6)*32 +: 32];
      return s ? 32'(s_f[f]) : a_f[f];
   endfunction
   function automatic bit hit(bit sel, logic [1:0] tr, logic [31:0] a);
      return sel && tr[1] && a >= 32'h1000 && a <= 32'h1FFF;
   endfunction
   task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, want);
      end
   endtask
   task automatic cyc();
      @(posedge HCLK);
      #1;
   endtask
   task automatic idle_bus();
      bus.HSEL = 1'b0;
      bus.HTRANS = HTRANS_IDLE;
      bus.HREADY = 1'b1;
      bus.HRESP = HRESP_OKAY;
   endtask
   task automatic model(bit w, logic [2:0] sz, int lat, bit e);
      int b = (lat - 1 > 7) ? 7 : lat - 1;
      m[w ? 1 : 0] = m[w ? 1 : 0] + 32'd1;
      m[w ? 3 : 2] = m[w ? 3 : 2] + (32'd1 << sz);
      m[4] = m[4] + 32'(lat);
      if (e) m[5] = m[5] + 32'd1;
      m[6+b] = m[6+b] + 32'd1;
      if (32'(lat) > m[14]) m[14] = 32'(lat);
   endtask
   task automatic xfer(bit w, logic [31:0] a, logic [2:0] sz, int waits, bit e, int clr_at = -1,
                       logic [1:0] tr = HTRANS_NONSEQ, bit sel = 1'b1);
      bit h = hit(sel, tr, a);
      bus.HSEL = sel; bus.HTRANS = tr; bus.HWRITE = w; bus.HADDR = a; bus.HSIZE = sz;
      cyc();
      idle_bus();
      for (int i = 0; i < waits; i++) begin
         bus.HREADY = 1'b0;
         bus.HRESP = (e && i == waits - 1) ? HRESP_ERROR : HRESP_OKAY;
         mon_clr = (i == clr_at);
         cyc();
         if (i == clr_at) begin t0 = cycle; m = '0; end
      end
      mon_clr = 1'b0;
      bus.HREADY = 1'b1;
      bus.HRESP = e ? HRESP_ERROR : HRESP_OKAY;
      cyc();
      bus.HRESP = HRESP_OKAY;
      if (h && (mon_en_a || mon_en_b)) model(w, sz, waits + 1, e);
   endtask
   task automatic burst(int n, logic [31:0] a, logic [2:0] sz);
      for (int i = 0; i < n; i++) begin
         bus.HSEL = 1'b1; bus.HTRANS = i == 0 ? HTRANS_NONSEQ : HTRANS_SEQ; bus.HWRITE = 1'b0;
         bus.HADDR = a + 32'(i) * (32'd1 << sz); bus.HSIZE = sz;
         cyc();
         if (hit(1'b1, bus.HTRANS, bus.HADDR) && (mon_en_a || mon_en_b)) model(1'b0, sz, 1, 1'b0);
      end
      idle_bus();
      cyc();
   endtask
   task automatic start_phase(bit s);
      mon_en_a = !s; mon_en_b = s; mon_clr = 1'b1;
      cyc();
      mon_clr = 1'b0; t0 = cycle; m = '0;
   endtask
   task automatic end_phase(string tag, bit s, int delay);
      rec_t exp;
      logic [31:0] want;
      int waited = 0;
      q.push_back(m);
      do begin
         @(negedge HCLK);
         waited++;
      end while (!(s ? s_v : a_v) && waited < 100);
      chk({tag, " window"}, 32'(cycle - t0), 32'(delay));
      exp = q.pop_front();
      for (int f = 0; f < 15; f++) begin
         want = exp[f];
         if (s && f != 14 && want > 32'd15) want = 32'd15;
         chk($sformatf("%s field%0d", tag, f), obs(s, f), want);
      end
      @(negedge HCLK);
      chk({tag, " pulse"}, 32'(s ? s_v : a_v), 32'd0);
      mon_en_a = 1'b0; mon_en_b = 1'b0;
   endtask
   initial begin
      idle_bus();
      bus.HWRITE = 1'b0; bus.HADDR = '0; bus.HSIZE = '0; bus.HWDATA = '0; bus.HRDATA = '0;
      repeat (2) cyc();
      for (int f = 0; f < 15; f++) begin
         chk($sformatf("reset a field%0d", f), obs(1'b0, f), 32'd0);
         chk($sformatf("reset s field%0d", f), obs(1'b1, f), 32'd0);
      end
      chk("reset valid", 32'({a_v, s_v}), 32'd0);
      HRESET = 1'b0;
      start_phase(1'b0); burst(4, 32'h1000, 3'd2); end_phase("rd4", 1'b0, 16);
      start_phase(1'b0); xfer(1'b1, 32'h1100, 3'd2, 3, 1'b0); end_phase("wr3wait", 1'b0, 16);
      start_phase(1'b0); xfer(1'b0, 32'h1200, 3'd2, 20, 1'b0, 10); end_phase("rd20wait", 1'b0, 16);
      start_phase(1'b0); xfer(1'b1, 32'h1300, 3'd2, 1, 1'b1); end_phase("error", 1'b0, 16);
      start_phase(1'b0);
      xfer(1'b0, 32'h2000, 3'd2, 0, 1'b0);
      xfer(1'b0, 32'h0FFC, 3'd2, 0, 1'b0);
      xfer(1'b0, 32'h1000, 3'd2, 0, 1'b0, -1, HTRANS_BUSY);
      xfer(1'b0, 32'h1000, 3'd2, 0, 1'b0, -1, HTRANS_NONSEQ, 1'b0);
      xfer(1'b0, 32'h1FFF, 3'd0, 0, 1'b0);
      xfer(1'b1, 32'h1000, 3'd1, 0, 1'b0);
      end_phase("filter", 1'b0, 16);
      start_phase(1'b0); burst(3, 32'h1000, 3'd2);
      start_phase(1'b0); burst(2, 32'h1400, 3'd2); end_phase("clr", 1'b0, 16);
      start_phase(1'b0);
      mon_en_a = 1'b0; xfer(1'b0, 32'h1000, 3'd2, 0, 1'b0);
      mon_en_a = 1'b1; xfer(1'b1, 32'h1004, 3'd2, 0, 1'b0);
      end_phase("mon_en", 1'b0, 18);
      start_phase(1'b1); burst(20, 32'h1000, 3'd0); end_phase("sat", 1'b1, 32);
      start_phase(1'b0);
      bus.HSEL = 1'b1; bus.HTRANS = HTRANS_NONSEQ; bus.HWRITE = 1'b1; bus.HADDR = 32'h1000; bus.HSIZE = 3'd2;
      cyc();
      idle_bus(); bus.HREADY = 1'b0;
      cyc();
      HRESET = 1'b1;
      cyc();
      HRESET = 1'b0; t0 = cycle; m = '0;
      for (int f = 0; f < 15; f++) chk($sformatf("midreset field%0d", f), obs(1'b0, f), 32'd0);
      bus.HREADY = 1'b1;
      cyc();
      end_phase("midreset", 1'b0, 16);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
